mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported backing memory between three requesters: debug port, MEM-stage data access, IF-stage fetch.
//  Sits between the RV32I pipeline and memory; sequences each access through a fixed-latency handshake.
//  Drives stall requests into the hazard unit while a pipeline requester waits.
// PARAMETERS
//  MEM_LATENCY   2   edges from mem_en sample to mem_rdata valid (>=1)
//  STARVE_LIMIT  4   consecutive data grants with i_req pending before fetch gets priority (>=1)
// PORTS
//  clk         in   1   core clock
//  rst         in   1   reset, asynchronous, active-low
//  dbg_req     in   1   debug access request (level, held until dbg_done)
//  dbg_addr    in   32  debug byte address ([1:0] ignored)
//  dbg_wdata   in   32  debug write data
//  dbg_we      in   4   debug byte write enables (0 = read)
//  dbg_rdata   out  32  debug read data, valid while dbg_done
//  dbg_done    out  1   one-cycle completion pulse
//  d_req/d_addr/d_wdata/d_we/d_rdata/d_done   same widths/meaning, MEM-stage data port
//  i_req       in   1   fetch request;  i_addr in 32 fetch byte address
//  i_rdata     out  32  fetch data;  i_done out 1 completion pulse
//  mem_en      out  1   memory access strobe, one cycle per transaction
//  mem_addr    out  30  word address
//  mem_wdata   out  32  write data;  mem_we out 4 byte enables
//  mem_rdata   in   32  read data, valid MEM_LATENCY edges after the mem_en cycle
//  stallF      out  1   i_req & ~i_done
//  stallM      out  1   d_req & ~d_done
// BEHAVIOUR
//  - rst low: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all *_done=0, all *_rdata=0, starve_cnt=0, stallF=stallM=0 (forced).
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. One transaction outstanding at a time.
//  - IDLE: at the edge where any req is high, latch winner id, addr[31:2], wdata, we; enter ACCESS.
//  - ACCESS: mem_en=1 in the first cycle only; mem_addr/mem_wdata/mem_we hold the latched values for the whole state.
//    Cycle counter runs MEM_LATENCY edges, then mem_rdata is captured into the winner's rdata register; enter RESP.
//  - RESP: winner's done=1 for exactly one cycle; next edge -> IDLE. Grant edge to done = MEM_LATENCY+1 edges.
//  - Writes (we!=0): done pulses as for reads; winner's rdata register is NOT updated.
//  - Requester must drop req in the cycle after its done; req high in IDLE is always a new transaction.
//  - req/addr changes during ACCESS/RESP are ignored; latched values are used.
//  - Priority at grant: dbg > data > inst, except when starve_cnt==STARVE_LIMIT: dbg > inst > data.
//  - starve_cnt: +1 on each data grant while i_req high (saturates at STARVE_LIMIT); cleared on inst grant or when i_req low in IDLE.
//  - Debug never preempts an in-flight transaction; it wins the next IDLE arbitration.
//  - Simultaneous events: all three reqs in the same IDLE cycle -> dbg granted; others wait, their stalls stay high.
//  - Reset during ACCESS/RESP: transaction aborted, no done pulse; memory write may or may not have occurred if mem_en already issued.
//  - stallF/stallM combinational from req/done; no other combinational in->out paths.
// STRUCTURE
//  - Shared header mem_arb_defs.vh: requester ids REQ_DBG=2'd0, REQ_DATA=2'd1, REQ_INST=2'd2; state codes IDLE/ACCESS/RESP.
//  - Sub-module mem_arb_priority: combinational picker (reqs, starve flag -> winner id, grant valid).
//  - Latency counter width = $clog2(MEM_LATENCY+1).
// TESTING
//  1. MEM_LATENCY=2, i_req, i_addr=0x100, mem_rdata=0xDEADBEEF -> one mem_en cycle, mem_addr=0x40, mem_we=0; i_done 3 edges after grant, i_rdata=0xDEADBEEF; stallF high until i_done.
//  2. d_req & i_req in the same IDLE cycle -> data served first (d_done), inst granted at the next IDLE; stallF high throughout.
//  3. STARVE_LIMIT=4, d_req reissued after every d_done, i_req held -> exactly 4 data grants, then inst granted; starve_cnt back to 0.
//  4. dbg_req raised mid data ACCESS -> data completes unchanged; dbg granted next IDLE ahead of pending i_req.
//  5. d_we=4'b0011, d_wdata=0x1234ABCD, d_addr=0x8 -> mem_we=4'b0011, mem_addr=0x2; d_done pulses; d_rdata keeps previous value.
//  6. rst low in the 2nd cycle of ACCESS -> all outputs to reset values next cycle, no done; after release, same request reissued completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: requester ids and FSM state codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        REQ_DBG  = 2'd0,
        REQ_DATA = 2'd1,
        REQ_INST = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational requester picker: debug first, then data or fetch depending on
// whether fetch has been starved long enough to jump ahead of data.
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
(
    input  logic    dbg_req,
    input  logic    data_req,
    input  logic    inst_req,
    input  logic    starve,
    output req_id_t winner,
    output logic    grant
);

    // Fixed-priority selection with starvation override between data and fetch
    always_comb begin
        winner = REQ_DBG;
        grant  = 1'b0;
        if (dbg_req) begin
            winner = REQ_DBG;
            grant  = 1'b1;
        end else if (starve && inst_req) begin
            winner = REQ_INST;
            grant  = 1'b1;
        end else if (data_req) begin
            winner = REQ_DATA;
            grant  = 1'b1;
        end else if (inst_req) begin
            winner = REQ_INST;
            grant  = 1'b1;
        end else begin
            winner = REQ_DBG;
            grant  = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between debug, MEM-stage data and IF-stage
// fetch, one fixed-latency transaction at a time, and raises pipeline stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_we,
    output logic [31:0] dbg_rdata,
    output logic        dbg_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic [31:0] d_rdata,
    output logic        d_done,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        mem_en,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    output logic        stallF,
    output logic        stallM
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_r;
    req_id_t          id_r;
    logic [CNT_W-1:0] cnt_r;
    logic [STV_W-1:0] starve_r;

    req_id_t          grant_id_s;
    logic             grant_vld_s;
    logic             starve_flag_s;
    logic [31:0]      sel_addr_s;
    logic [31:0]      sel_wdata_s;
    logic [3:0]       sel_we_s;
    logic             unused_addr_bits_s;

    assign starve_flag_s      = (starve_r == STV_W'(STARVE_LIMIT));
    assign unused_addr_bits_s = ^sel_addr_s[1:0];

    mem_arb_priority u_priority (
        .dbg_req  (dbg_req),
        .data_req (d_req),
        .inst_req (i_req),
        .starve   (starve_flag_s),
        .winner   (grant_id_s),
        .grant    (grant_vld_s)
    );

    // Route the winning requester's address, data and enables to the latch point
    always_comb begin
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
        sel_we_s    = 4'h0;
        case (grant_id_s)
            REQ_DBG: begin
                sel_addr_s  = dbg_addr;
                sel_wdata_s = dbg_wdata;
                sel_we_s    = dbg_we;
            end
            REQ_DATA: begin
                sel_addr_s  = d_addr;
                sel_wdata_s = d_wdata;
                sel_we_s    = d_we;
            end
            REQ_INST: begin
                sel_addr_s  = i_addr;
                sel_wdata_s = 32'h0;
                sel_we_s    = 4'h0;
            end
            default: begin
                sel_addr_s  = 32'h0;
                sel_wdata_s = 32'h0;
                sel_we_s    = 4'h0;
            end
        endcase
    end

    // Transaction FSM: grant in IDLE, wait out memory latency in ACCESS, pulse done in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            id_r      <= REQ_DBG;
            cnt_r     <= {CNT_W{1'b0}};
            starve_r  <= {STV_W{1'b0}};
            mem_en    <= 1'b0;
            mem_addr  <= 30'h0;
            mem_wdata <= 32'h0;
            mem_we    <= 4'h0;
            dbg_done  <= 1'b0;
            d_done    <= 1'b0;
            i_done    <= 1'b0;
            dbg_rdata <= 32'h0;
            d_rdata   <= 32'h0;
            i_rdata   <= 32'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_vld_s) begin
                        id_r      <= grant_id_s;
                        mem_en    <= 1'b1;
                        mem_addr  <= sel_addr_s[31:2];
                        mem_wdata <= sel_wdata_s;
                        mem_we    <= sel_we_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= ACCESS;
                    end
                    // Starvation only accumulates while fetch is actually waiting
                    if (grant_vld_s && (grant_id_s == REQ_INST)) begin
                        starve_r <= {STV_W{1'b0}};
                    end else if (!i_req) begin
                        starve_r <= {STV_W{1'b0}};
                    end else if (grant_vld_s && (grant_id_s == REQ_DATA) && !starve_flag_s) begin
                        starve_r <= starve_r + STV_W'(1);
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    if (cnt_r == CNT_W'(MEM_LATENCY)) begin
                        state_r <= RESP;
                        case (id_r)
                            REQ_DBG: begin
                                dbg_done <= 1'b1;
                                if (mem_we == 4'h0) dbg_rdata <= mem_rdata;
                            end
                            REQ_DATA: begin
                                d_done <= 1'b1;
                                if (mem_we == 4'h0) d_rdata <= mem_rdata;
                            end
                            REQ_INST: begin
                                i_done <= 1'b1;
                                if (mem_we == 4'h0) i_rdata <= mem_rdata;
                            end
                            default: state_r <= IDLE;
                        endcase
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    dbg_done <= 1'b0;
                    d_done   <= 1'b0;
                    i_done   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Stalls are forced low while reset is asserted
    assign stallF = rst & i_req & ~i_done;
    assign stallM = rst & d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_req, d_req, i_req;
    logic [31:0] dbg_addr, dbg_wdata, d_addr, d_wdata, i_addr;
    logic [3:0]  dbg_we, d_we;
    logic [31:0] dbg_rdata, d_rdata, i_rdata;
    logic        dbg_done, d_done, i_done;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        stallF, stallM;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(d_rdata), .d_done(d_done),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stallF(stallF), .stallM(stallM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts negedges until the selected done is seen (bounded) and checks the count
    task automatic wait_done(input int sel, input string tag, input int exp_n);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (sel == 0) ? dbg_done : (sel == 1) ? d_done : i_done;
        end
        chk({tag, "_latency"}, n, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcount;
        rst = 1'b0;
        dbg_req = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_we = 4'h0;
        d_req = 1'b1;   d_addr = 32'h0;   d_wdata = 32'h0;   d_we = 4'h0;
        i_req = 1'b1;   i_addr = 32'h0;   mem_rdata = 32'h0;

        // Reset state, stalls forced low even with requests pending
        repeat (2) @(negedge clk);
        chk("rst_mem_en", mem_en, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", mem_we, 32'h0);
        chk("rst_i_done", i_done, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_stallF", stallF, 32'h0);
        chk("rst_stallM", stallM, 32'h0);
        d_req = 1'b0; i_req = 1'b0;
        rst = 1'b1;

        // Test 1: single fetch read
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        #1 chk("t1_stallF_req", stallF, 32'h1);
        @(negedge clk);
        chk("t1_mem_en", mem_en, 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_mem_we", mem_we, 32'h0);
        chk("t1_i_done_e1", i_done, 32'h0);
        @(negedge clk);
        chk("t1_mem_en_off", mem_en, 32'h0);
        chk("t1_stallF_wait", stallF, 32'h1);
        @(negedge clk);
        chk("t1_i_done_e2", i_done, 32'h0);
        @(negedge clk);
        chk("t1_i_done", i_done, 32'h1);
        chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("t1_stallF_done", stallF, 32'h0);
        i_req = 1'b0;
        @(negedge clk);
        chk("t1_i_done_pulse", i_done, 32'h0);

        // Test 2: data and fetch together, data served first
        d_req = 1'b1; d_addr = 32'h20; i_req = 1'b1; i_addr = 32'h104; mem_rdata = 32'h11111111;
        #1 chk("t2_stallM", stallM, 32'h1);
        wait_done(1, "t2_d", 4);
        chk("t2_d_rdata", d_rdata, 32'h11111111);
        chk("t2_i_waiting", i_done, 32'h0);
        chk("t2_stallF", stallF, 32'h1);
        d_req = 1'b0; mem_rdata = 32'h22222222;
        wait_done(2, "t2_i", 5);
        chk("t2_i_rdata", i_rdata, 32'h22222222);
        i_req = 1'b0;

        // Test 3: fetch starvation limit
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h300; i_req = 1'b1; i_addr = 32'h200; mem_rdata = 32'h33333333;
        dcount = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (d_done) dcount++;
            if (i_done) break;
        end
        chk("t3_inst_served", i_done, 32'h1);
        chk("t3_data_grants", dcount, 32'd4);
        chk("t3_starve_cnt", dut.starve_r, 32'h0);
        d_req = 1'b0; i_req = 1'b0;

        // Test 4: debug arriving mid data access waits, then beats fetch
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h40; mem_rdata = 32'h44444444;
        @(negedge clk);
        chk("t4_mem_addr", mem_addr, 32'h10);
        dbg_req = 1'b1; dbg_addr = 32'h80; i_req = 1'b1; i_addr = 32'h500; d_addr = 32'hFFC;
        wait_done(1, "t4_d", 3);
        chk("t4_d_rdata", d_rdata, 32'h44444444);
        chk("t4_dbg_wait", dbg_done, 32'h0);
        d_req = 1'b0; mem_rdata = 32'h55555555;
        wait_done(0, "t4_dbg", 5);
        chk("t4_dbg_rdata", dbg_rdata, 32'h55555555);
        chk("t4_i_wait", i_done, 32'h0);
        dbg_req = 1'b0; mem_rdata = 32'h66666666;
        wait_done(2, "t4_i", 5);
        chk("t4_i_rdata", i_rdata, 32'h66666666);
        i_req = 1'b0;

        // Test 5: partial write leaves read data untouched
        @(negedge clk);
        d_req = 1'b1; d_we = 4'b0011; d_wdata = 32'h1234ABCD; d_addr = 32'h8; mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("t5_mem_en", mem_en, 32'h1);
        chk("t5_mem_we", mem_we, 32'h3);
        chk("t5_mem_addr", mem_addr, 32'h2);
        chk("t5_mem_wdata", mem_wdata, 32'h1234ABCD);
        wait_done(1, "t5_d", 3);
        chk("t5_d_rdata_kept", d_rdata, 32'h44444444);
        d_req = 1'b0; d_we = 4'h0;

        // Test 6: reset in the second ACCESS cycle aborts, reissue completes
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h600; mem_rdata = 32'h88888888;
        @(negedge clk);
        chk("t6_mem_en", mem_en, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_mem_en", mem_en, 32'h0);
        chk("t6_rst_mem_addr", mem_addr, 32'h0);
        chk("t6_rst_i_rdata", i_rdata, 32'h0);
        chk("t6_rst_stallF", stallF, 32'h0);
        @(negedge clk);
        chk("t6_no_done", i_done, 32'h0);
        rst = 1'b1;
        wait_done(2, "t6_i", 4);
        chk("t6_i_rdata", i_rdata, 32'h88888888);
        i_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
